// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL LOCK signal and sequences a clean synchronous active-low reset
// for downstream logic, counting lock-loss events for status reporting.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lock_async,
    input  logic             clr_count,
    output logic             rst_out_n,
    output logic             lock_sync,
    output logic             loss_event,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int unsigned MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        WAIT   = 2'd1,
        STABLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   loss_d;
    logic [CNT_W-1:0]       count_base;
    logic [CNT_W-1:0]       count_d;

    assign lock_sync = sync_q[SYNC_STAGES-1];
    assign state     = state_q;

    // Next-state and cycle-counter logic; every state change clears the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = 1'b0;
        case (state_q)
            HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (lock_sync) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_sync) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    loss_d  = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear takes effect first so a simultaneous loss still lands as a count of one.
    always_comb begin
        count_base = clr_count ? '0 : loss_count;
        count_d    = count_base;
        if (loss_d && (count_base != '1)) begin
            count_d = count_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= '0;
            state_q    <= HOLD;
            cnt_q      <= '0;
            rst_out_n  <= 1'b0;
            loss_event <= 1'b0;
            loss_count <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], lock_async};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_n  <= (state_d == RUN);
            loss_event <= loss_d;
            loss_count <= count_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: sequencing, latency, glitch rejection,
// loss counting with saturation/clear, and block reset from RUN.
module tb_pll_lock_supervisor;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset_n;
    logic             lock_async;
    logic             clr_count;
    logic             rst_out_n;
    logic             lock_sync;
    logic             loss_event;
    logic [CNT_W-1:0] loss_count;
    logic [1:0]       state;

    int unsigned tests;
    int unsigned fails;

    pll_lock_supervisor #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .HOLD_CYCLES  (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lock_async(lock_async),
        .clr_count (clr_count),
        .rst_out_n (rst_out_n),
        .lock_sync (lock_sync),
        .loss_event(loss_event),
        .loss_count(loss_count),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (state != 2'd3 && n < 60) begin
            step();
            if (state != 2'd3) chk("relock_rst_low", 32'(rst_out_n), 32'd0);
            n++;
        end
        chk("wait_run", 32'(state), 32'd3);
        chk("wait_run_rst", 32'(rst_out_n), 32'd1);
    endtask

    // One-cycle lock drop from RUN; loss is reported two edges after the sampling edge.
    task automatic lose_lock(input logic clr_at_loss, input logic [31:0] exp_count);
        lock_async = 1'b0;
        step();
        lock_async = 1'b1;
        step();
        chk("loss_pre_state", 32'(state), 32'd3);
        chk("loss_pre_event", 32'(loss_event), 32'd0);
        clr_count = clr_at_loss;
        step();
        clr_count = 1'b0;
        chk("loss_event", 32'(loss_event), 32'd1);
        chk("loss_count", 32'(loss_count), exp_count);
        chk("loss_state", 32'(state), 32'd0);
        chk("loss_rst", 32'(rst_out_n), 32'd0);
        step();
        chk("loss_pulse_end", 32'(loss_event), 32'd0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset_n    = 1'b0;
        lock_async = 1'b0;
        clr_count  = 1'b0;

        // Test 1: reset, then HOLD for exactly four cycles.
        step();
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rst_out", 32'(rst_out_n), 32'd0);
        chk("rst_count", 32'(loss_count), 32'd0);
        chk("rst_event", 32'(loss_event), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_state", 32'(state), 32'd0);
            chk("hold_rst", 32'(rst_out_n), 32'd0);
        end
        step();
        chk("hold_to_wait", 32'(state), 32'd1);
        chk("wait_count", 32'(loss_count), 32'd0);

        // Test 2: release latency is SYNC_STAGES + STABLE_CYCLES edges.
        lock_async = 1'b1;
        step();
        chk("e0_lock_sync", 32'(lock_sync), 32'd0);
        step();
        chk("e1_lock_sync", 32'(lock_sync), 32'd1);
        chk("e1_state", 32'(state), 32'd1);
        step();
        chk("e2_state", 32'(state), 32'd2);
        for (int i = 3; i < 10; i++) begin
            step();
            chk("stable_rst_low", 32'(rst_out_n), 32'd0);
            chk("stable_state", 32'(state), 32'd2);
        end
        step();
        chk("e10_state", 32'(state), 32'd3);
        chk("e10_rst", 32'(rst_out_n), 32'd1);

        // Test 4: loss in RUN, then full HOLD before relock.
        lose_lock(1'b0, 32'd1);
        step();
        step();
        chk("post_loss_hold", 32'(state), 32'd0);
        step();
        chk("post_loss_wait", 32'(state), 32'd1);
        step();
        chk("post_loss_stable", 32'(state), 32'd2);

        // Test 3: one-cycle drop after five stable cycles restarts the window.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stable_pre_glitch", 32'(rst_out_n), 32'd0);
        end
        lock_async = 1'b0;
        step();
        lock_async = 1'b1;
        step();
        chk("glitch_still_stable", 32'(state), 32'd2);
        step();
        chk("glitch_to_wait", 32'(state), 32'd1);
        chk("glitch_no_event", 32'(loss_event), 32'd0);
        chk("glitch_count", 32'(loss_count), 32'd1);
        chk("glitch_rst", 32'(rst_out_n), 32'd0);
        step();
        chk("glitch_restable", 32'(state), 32'd2);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("restable_rst_low", 32'(rst_out_n), 32'd0);
            chk("restable_event", 32'(loss_event), 32'd0);
        end
        step();
        chk("rerun_state", 32'(state), 32'd3);
        chk("rerun_rst", 32'(rst_out_n), 32'd1);

        // Test 5: clear, then five losses saturating at 3, then clear coincident with a loss.
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_count", 32'(loss_count), 32'd0);
        chk("clr_run", 32'(state), 32'd3);
        for (int i = 1; i <= 5; i++) begin
            lose_lock(1'b0, (i > 3) ? 32'd3 : 32'(i));
            wait_run();
        end
        lose_lock(1'b1, 32'd1);
        wait_run();

        // Test 6: block reset from RUN with loss_count=2.
        lose_lock(1'b0, 32'd2);
        wait_run();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrun_rst", 32'(rst_out_n), 32'd0);
        chk("midrun_count", 32'(loss_count), 32'd0);
        chk("midrun_event", 32'(loss_event), 32'd0);
        chk("midrun_state", 32'(state), 32'd0);
        step();
        chk("midrun_event_after", 32'(loss_event), 32'd0);
        chk("midrun_hold", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumes the LOCK output of the board's rPLL (100 MHz in, 12 MHz out) in the PLL output clock domain.
- Synchronises and qualifies LOCK, then generates a clean synchronous active-low reset for the ADC-capture/serial logic.
- Holds that reset until LOCK has been stable for a programmable time; re-asserts it on lock loss.
- Counts lock-loss events for the serial status report.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on lock_async (legal ≥2).
- STABLE_CYCLES, 1024, consecutive clk cycles lock_sync must stay 1 before reset release (≥1).
- HOLD_CYCLES, 16, minimum cycles the reset is held after a lock loss or block reset (≥1).
- CNT_W, 8, width of the lock-loss counter.

Ports:
- clk  in  1  PLL output clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- lock_async  in  1  raw PLL LOCK, asynchronous to clk.
- clr_count  in  1  synchronous clear of loss_count.
- rst_out_n  out  1  registered active-low reset to downstream logic.
- lock_sync  out  1  synchronised LOCK (last sync stage).
- loss_event  out  1  one-cycle pulse per lock loss while running.
- loss_count  out  CNT_W  saturating lock-loss count.
- state  out  2  FSM state: HOLD=0, WAIT=1, STABLE=2, RUN=3.

Behaviour:
- **Reset (reset_n=0 at an edge):**
  - sync chain=0, state=HOLD, cycle counter=0.
  - rst_out_n=0, loss_event=0, loss_count=0.
  - Reset mid-RUN drops rst_out_n on that edge and produces no loss_event.
- **Synchroniser:** lock_sync = lock_async delayed by SYNC_STAGES edges. No other use of lock_async.
- **Cycle counter:** width clog2(max(STABLE_CYCLES,HOLD_CYCLES))+1. Cleared on every state change.
- **HOLD:**
  - Counter increments each cycle; lock_sync is ignored.
  - When counter==HOLD_CYCLES-1, go to WAIT. HOLD lasts exactly HOLD_CYCLES cycles.
- **WAIT:** if lock_sync=1, go to STABLE with counter=0; otherwise stay.
- **STABLE:**
  - If lock_sync=0, go to WAIT. This is a glitch, not counted as a loss.
  - Else if counter==STABLE_CYCLES-1, go to RUN.
  - Else counter increments.
- **RUN:** if lock_sync=0, go to HOLD, pulse loss_event for exactly one cycle (registered, same edge as the transition), and increment loss_count.
- **rst_out_n:** registered, equal to (next_state==RUN); high exactly while state==RUN. No combinational path from any input.
- **Release latency:** with lock_async held 1, rst_out_n rises on the edge SYNC_STAGES+STABLE_CYCLES edges after the edge that first samples lock_async=1, provided the FSM was already in WAIT.
- **Assert latency:** lock_async falling while in RUN makes rst_out_n fall on the edge SYNC_STAGES edges after the first edge that samples it low.
- **loss_count:**
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_count=1 clears it.
  - clr_count and a loss in the same cycle give loss_count=1 (increment applied after clear).
  - Holding clr_count does not block loss_event.
- **Lock flicker:**
  - lock_sync returning high during HOLD has no effect until HOLD completes.
  - Any drop during STABLE restarts the full STABLE_CYCLES window.
- state output is the registered FSM state.

Test Plan:
1. SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4. reset_n low 3 cycles, release, lock_async=0 → state HOLD for 4 cycles then WAIT; rst_out_n=0 throughout, loss_count=0.
2. Same config, in WAIT, raise lock_async before edge E0 → lock_sync=1 after E1; state=STABLE after E2; rst_out_n=1 and state=RUN after edge E0+10 and not before.
3. In STABLE, drop lock_async for one cycle after 5 stable cycles → state returns to WAIT, loss_event never pulses, loss_count=0; rst_out_n rises only after a fresh 8-cycle window.
4. In RUN, drop lock_async for 1 cycle → rst_out_n=0 two edges after the sample, loss_event high exactly 1 cycle, loss_count=1; rst_out_n stays low ≥4 HOLD cycles, then ≥8 STABLE cycles before re-release.
5. CNT_W=2, force 5 losses → loss_count 1,2,3,3,3. Assert clr_count in the same cycle as a 6th loss → loss_count=1.
6. In RUN with loss_count=2, pull reset_n low for 1 cycle → rst_out_n=0 and loss_count=0 on that edge, no loss_event, state=HOLD.
